// File: rtl/bouncing_square_gen_if.sv
// Pixel-stream bundle between the VGA timing controller and the bouncing-square generator.
// master drives timing and run control; slave returns colour, frame pulse and bounce count.
interface bouncing_square_gen_if;
   logic        p_tick;
   logic        video_on;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        run;
   logic [11:0] rgb;
   logic        frame_tick;
   logic [7:0]  bounce_count;

   modport master (
      output p_tick, video_on, x, y, run,
      input  rgb, frame_tick, bounce_count
   );

   modport slave (
      input  p_tick, video_on, x, y, run,
      output rgb, frame_tick, bounce_count
   );
endinterface

// File: rtl/bouncing_square_gen.sv
// Animated pixel stage: a square sprite that moves once per frame, bounces off the
// screen edges and counts bounces; produces registered 12-bit RGB from the timing stream.
module bouncing_square_gen #(
   parameter int          H_DISPLAY = 640,
   parameter int          V_DISPLAY = 480,
   parameter int          SQ_SIZE   = 64,
   parameter int          SQ_VEL    = 2,
   parameter logic [11:0] SQ_COLOR  = 12'hF00,
   parameter logic [11:0] BG_COLOR  = 12'h0FF
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   bouncing_square_gen_if.slave vga
);

   typedef enum logic {
      RUN    = 1'b0,
      PAUSED = 1'b1
   } state_t;

   localparam logic [10:0] VEL     = 11'(SQ_VEL);
   localparam logic [10:0] SIZE_M1 = 11'(SQ_SIZE - 1);
   localparam logic [9:0]  FRAME_Y = 10'(V_DISPLAY + 1);

   state_t      state_reg;
   logic [10:0] pos_reg [2];
   logic [10:0] pos_next [2];
   logic [1:0]  dir_reg;      // bit set = moving toward increasing coordinate
   logic [1:0]  dir_next;
   logic [1:0]  bounce;
   logic [1:0]  in_span;
   logic [9:0]  pix_coord [2];
   logic [7:0]  bounce_count_reg;
   logic [7:0]  bounce_count_next;
   logic [8:0]  count_sum;
   logic        frame_tick_reg;
   logic [11:0] rgb_reg;
   logic [11:0] rgb_next;

   assign pix_coord[0] = vga.x;
   assign pix_coord[1] = vga.y;

   // Axis 0 is horizontal, axis 1 vertical; both share the same clamp-and-reflect rule.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_axis
         localparam logic [10:0] LIMIT = 11'(((gi == 0) ? H_DISPLAY : V_DISPLAY) - SQ_SIZE);
         logic [10:0] fwd;
         logic [10:0] back;

         assign fwd  = pos_reg[gi] + VEL;
         assign back = pos_reg[gi] - VEL;

         assign bounce[gi]   = dir_reg[gi] ? (fwd > LIMIT) : (pos_reg[gi] < VEL);
         assign dir_next[gi] = dir_reg[gi] ^ bounce[gi];
         assign pos_next[gi] = bounce[gi] ? (dir_reg[gi] ? LIMIT : 11'd0)
                                          : (dir_reg[gi] ? fwd : back);

         assign in_span[gi] = ({1'b0, pix_coord[gi]} >= pos_reg[gi]) &&
                              ({1'b0, pix_coord[gi]} <= pos_reg[gi] + SIZE_M1);
      end
   endgenerate

   // A simultaneous corner hit adds two; the sum is one bit wider so saturation is exact.
   assign count_sum         = {1'b0, bounce_count_reg} + {8'd0, bounce[0]} + {8'd0, bounce[1]};
   assign bounce_count_next = count_sum[8] ? 8'hFF : count_sum[7:0];

   always_comb begin
      rgb_next = BG_COLOR;
      if (!vga.video_on) begin
         rgb_next = 12'h000;
      end else if (&in_span) begin
         rgb_next = SQ_COLOR;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (!reset) begin
         state_reg        <= RUN;
         pos_reg[0]       <= 11'd0;
         pos_reg[1]       <= 11'd0;
         dir_reg          <= 2'b11;
         bounce_count_reg <= 8'd0;
         frame_tick_reg   <= 1'b0;
         rgb_reg          <= 12'h000;
      end else begin
         frame_tick_reg <= vga.p_tick && (vga.x == 10'd0) && (vga.y == FRAME_Y);

         if (vga.p_tick) begin
            rgb_reg <= rgb_next;
         end

         // The pulse lands in vertical blanking, so the sprite never moves mid-frame.
         if (frame_tick_reg) begin
            case (state_reg)
               RUN: begin
                  if (!vga.run) begin
                     state_reg <= PAUSED;
                  end else begin
                     pos_reg[0]       <= pos_next[0];
                     pos_reg[1]       <= pos_next[1];
                     dir_reg          <= dir_next;
                     bounce_count_reg <= bounce_count_next;
                  end
               end
               PAUSED: begin
                  if (vga.run) begin
                     state_reg <= RUN;
                  end
               end
            endcase
         end
      end
   end

   assign vga.rgb          = rgb_reg;
   assign vga.frame_tick   = frame_tick_reg;
   assign vga.bounce_count = bounce_count_reg;

endmodule

// File: tb/tb_bouncing_square_gen.sv
// Directed bench for bouncing_square_gen: a 64px/2px-per-frame instance and a
// 160px/80px-per-frame instance (frequent corner hits) share one stimulus stream.
module tb_bouncing_square_gen;

   logic clk_100MHz = 1'b0;
   logic reset;

   always #5 clk_100MHz = ~clk_100MHz;

   bouncing_square_gen_if bus_a ();
   bouncing_square_gen_if bus_b ();

   bouncing_square_gen #(.SQ_SIZE(64), .SQ_VEL(2)) dut_a (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .vga        (bus_a)
   );

   bouncing_square_gen #(.SQ_SIZE(160), .SQ_VEL(80)) dut_b (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .vga        (bus_b)
   );

   typedef struct {
      string       tag;
      logic [11:0] exp_a;
      logic [11:0] exp_b;
   } exp_t;

   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;
   int frames     = 0;

   // Reference model, index 0 = dut_a, 1 = dut_b
   int m_size [2] = '{64, 160};
   int m_vel  [2] = '{2, 80};
   int m_px   [2];
   int m_py   [2];
   int m_cnt  [2];
   int m_moves[2];
   int m_bounces[2];
   bit m_dx   [2];
   bit m_dy   [2];
   bit m_paused[2];
   logic [11:0] last_a, last_b;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit p, input bit von, input int xx, input int yy);
      bus_a.p_tick = p;  bus_a.video_on = von;  bus_a.x = 10'(xx);  bus_a.y = 10'(yy);
      bus_b.p_tick = p;  bus_b.video_on = von;  bus_b.x = 10'(xx);  bus_b.y = 10'(yy);
   endtask

   task automatic set_run(input bit r);
      bus_a.run = r;
      bus_b.run = r;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_px[i] = 0;  m_py[i] = 0;  m_cnt[i] = 0;  m_moves[i] = 0;  m_bounces[i] = 0;
         m_dx[i] = 1'b1;  m_dy[i] = 1'b1;  m_paused[i] = 1'b0;
      end
   endtask

   task automatic model_frame(input int i, input bit r);
      int b    = 0;
      int hmax = 640 - m_size[i];
      int vmax = 480 - m_size[i];
      if (m_paused[i]) begin
         if (r) m_paused[i] = 1'b0;
      end else if (!r) begin
         m_paused[i] = 1'b1;
      end else begin
         if (m_dx[i]) begin
            if (m_px[i] + m_vel[i] > hmax) begin m_px[i] = hmax; m_dx[i] = 1'b0; b++; end
            else m_px[i] = m_px[i] + m_vel[i];
         end else begin
            if (m_px[i] < m_vel[i]) begin m_px[i] = 0; m_dx[i] = 1'b1; b++; end
            else m_px[i] = m_px[i] - m_vel[i];
         end
         if (m_dy[i]) begin
            if (m_py[i] + m_vel[i] > vmax) begin m_py[i] = vmax; m_dy[i] = 1'b0; b++; end
            else m_py[i] = m_py[i] + m_vel[i];
         end else begin
            if (m_py[i] < m_vel[i]) begin m_py[i] = 0; m_dy[i] = 1'b1; b++; end
            else m_py[i] = m_py[i] - m_vel[i];
         end
         m_moves[i]++;
      end
      m_bounces[i] = b;
      m_cnt[i]     = (m_cnt[i] + b > 255) ? 255 : m_cnt[i] + b;
   endtask

   function automatic logic [11:0] exp_pix(input int i, input bit von, input int xx, input int yy);
      if (!von) return 12'h000;
      if (xx >= m_px[i] && xx < m_px[i] + m_size[i] && yy >= m_py[i] && yy < m_py[i] + m_size[i])
         return 12'hF00;
      return 12'h0FF;
   endfunction

   // One p_tick pixel; expectation queued at drive time, popped once rgb is registered.
   task automatic pixel(input string tag, input int xx, input int yy, input bit von);
      exp_t e;
      drive(1'b1, von, xx, yy);
      sb.push_back('{tag, exp_pix(0, von, xx, yy), exp_pix(1, von, xx, yy)});
      step();
      drive(1'b0, 1'b0, 0, 0);
      if (sb.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_a"}, bus_a.rgb, e.exp_a);
         check({e.tag, "_b"}, bus_b.rgb, e.exp_b);
         last_a = e.exp_a;
         last_b = e.exp_b;
      end
   endtask

   task automatic probe_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         int px = m_px[i];
         int py = m_py[i];
         int s  = m_size[i];
         pixel({tag, "_tl"}, px, py, 1'b1);
         pixel({tag, "_br"}, px + s - 1, py + s - 1, 1'b1);
         if (px > 0)       pixel({tag, "_left"},  px - 1, py, 1'b1);
         if (px + s < 640) pixel({tag, "_right"}, px + s, py, 1'b1);
         if (py > 0)       pixel({tag, "_above"}, px, py - 1, 1'b1);
         if (py + s < 480) pixel({tag, "_below"}, px, py + s, 1'b1);
      end
   endtask

   // One frame: a single p_tick at (0, V_DISPLAY+1), then the update edge.
   task automatic frame(input bit r);
      set_run(r);
      drive(1'b1, 1'b0, 0, 481);
      step();
      drive(1'b0, 1'b0, 0, 0);
      check("frame_tick_hi_a", bus_a.frame_tick, 1'b1);
      check("frame_tick_hi_b", bus_b.frame_tick, 1'b1);
      step();
      check("frame_tick_lo_a", bus_a.frame_tick, 1'b0);
      check("frame_tick_lo_b", bus_b.frame_tick, 1'b0);
      model_frame(0, r);
      model_frame(1, r);
      check("count_a", bus_a.bounce_count, m_cnt[0]);
      check("count_b", bus_b.bounce_count, m_cnt[1]);
      frames++;
      $display("frame %0d run=%0b count_a=%0d count_b=%0d", frames, r,
               bus_a.bounce_count, bus_b.bounce_count);
   endtask

   initial begin
      int prev_b;
      int extra;

      reset = 1'b0;
      set_run(1'b0);
      drive(1'b0, 1'b0, 0, 0);
      model_reset();
      last_a = 12'h000;
      last_b = 12'h000;

      // Reset held with live pixel and frame-position ticks: outputs must stay cleared
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) drive(1'b1, 1'b1, 0, 0);
         else            drive(1'b1, 1'b0, 0, 481);
         step();
         check("rst_rgb_a", bus_a.rgb, 12'h000);
         check("rst_rgb_b", bus_b.rgb, 12'h000);
         check("rst_count_a", bus_a.bounce_count, 8'd0);
         check("rst_frame_tick_a", bus_a.frame_tick, 1'b0);
      end
      reset = 1'b1;
      drive(1'b0, 1'b0, 0, 481);
      step();
      check("no_ptick_frame_a", bus_a.frame_tick, 1'b0);
      $display("reset released");

      // Sweep around the frame position: only (0,481) with p_tick fires the pulse
      for (int yy = 480; yy <= 482; yy++) begin
         for (int xx = 0; xx <= 2; xx++) begin
            drive(1'b1, 1'b0, xx, yy);
            step();
            check("sweep_tick_a", bus_a.frame_tick, (xx == 0 && yy == 481));
            check("sweep_tick_b", bus_b.frame_tick, (xx == 0 && yy == 481));
            drive(1'b0, 1'b0, xx, yy);
            step();
            check("sweep_tick_off_a", bus_a.frame_tick, 1'b0);
            if (xx == 0 && yy == 481) begin
               model_frame(0, 1'b0);
               model_frame(1, 1'b0);
            end
         end
      end

      // Pixel colouring with the square at the origin
      pixel("pix_0_0", 0, 0, 1'b1);
      pixel("pix_63_63", 63, 63, 1'b1);
      pixel("pix_64_0", 64, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 0, 0);
         step();
         check("hold_a", bus_a.rgb, last_a);
         check("hold_b", bus_b.rgb, last_b);
      end
      pixel("pix_blank", 100, 200, 1'b0);
      $display("pixel colouring done");

      // Resume from pause (no motion on that frame), then ten moves
      frame(1'b1);
      for (int i = 0; i < 10; i++) frame(1'b1);
      probe_all("motion");

      // Pause: three frames frozen, then resume without moving, then move again
      for (int i = 0; i < 3; i++) begin
         frame(1'b0);
         probe_all("paused");
      end
      frame(1'b1);
      probe_all("resume");
      frame(1'b1);
      probe_all("moved");

      // Run on past the bottom-wall and right-wall bounces of the 64px square
      for (int i = 0; i < 400 && m_moves[0] < 292; i++) begin
         frame(1'b1);
         probe_all("wall");
      end
      check("wall_moves_reached", m_moves[0] >= 292, 1'b1);

      // Corner hits on the large square, then saturation at 255
      extra = 0;
      for (int i = 0; i < 3000 && extra < 30; i++) begin
         prev_b = m_cnt[1];
         frame(1'b1);
         if (m_bounces[1] == 2)
            check("corner_plus2_b", bus_b.bounce_count, (prev_b + 2 > 255) ? 255 : prev_b + 2);
         if (i % 4 == 0) probe_all("sat");
         if (m_cnt[1] == 255) extra++;
      end
      check("saturated_b", bus_b.bounce_count, 8'd255);

      // Reset mid-line overrides pixel update
      set_run(1'b1);
      drive(1'b1, 1'b1, 100, 50);
      reset = 1'b0;
      step();
      check("midrst_rgb_a", bus_a.rgb, 12'h000);
      check("midrst_rgb_b", bus_b.rgb, 12'h000);
      check("midrst_count_a", bus_a.bounce_count, 8'd0);
      check("midrst_count_b", bus_b.bounce_count, 8'd0);
      // Reset on the frame-position tick suppresses the pulse
      drive(1'b1, 1'b0, 0, 481);
      step();
      reset = 1'b1;
      drive(1'b0, 1'b0, 0, 0);
      check("midrst_frame_tick_a", bus_a.frame_tick, 1'b0);
      step();
      check("midrst_frame_tick_b", bus_b.frame_tick, 1'b0);
      model_reset();
      last_a = 12'h000;
      last_b = 12'h000;
      probe_all("after_reset");
      $display("mid-operation reset done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
